// File: rtl/ctrl_sequencer_if.sv
// Program-load / playback bus between a host and ctrl_sequencer.
// The master drives the program store and start; the slave returns the datapath control stream.
interface ctrl_sequencer_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [16:0]   prog_data;
  logic          start;
  logic [AW:0]   len;
  logic [8:0]    c;
  logic [7:0]    imm;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, len,
    input  c, imm, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, len,
    output c, imm, busy, done, pc
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Program-store sequencer: plays {imm, c} words one per issue edge onto the ALU datapath.
// Optional SEQ_STEP_EN adds a 'step' input that gates word issue while running.
module ctrl_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef SEQ_STEP_EN
  input  logic step,
`endif
  ctrl_sequencer_if.slave bus
);

  localparam logic [8:0]  NOP_C   = 9'h1F8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [16:0]   mem [DEPTH];
  logic [AW:0]   n_q;
  logic [AW-1:0] pc_q;
  logic [8:0]    c_q;
  logic [7:0]    imm_q;
  logic          busy_q;
  logic          done_q;

  logic [AW:0]   len_clip;
  logic [AW-1:0] pc_nxt;
  logic          last;
  logic          adv;

  assign len_clip = (bus.len > DEPTH_W) ? DEPTH_W : bus.len;
  assign pc_nxt   = pc_q + AW'(1);
  assign last     = ({1'b0, pc_q} == (n_q - (AW+1)'(1)));

`ifdef SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Store has no reset so a program survives a mid-run abort.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == IDLE)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      n_q    <= '0;
      pc_q   <= '0;
      c_q    <= NOP_C;
      imm_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              state          <= RUN;
              busy_q         <= 1'b1;
              n_q            <= len_clip;
              pc_q           <= '0;
              {imm_q, c_q}   <= mem[0];
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (adv) begin
            if (last) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pc_q   <= '0;
              c_q    <= NOP_C;
              imm_q  <= '0;
            end else begin
              pc_q         <= pc_nxt;
              {imm_q, c_q} <= mem[pc_nxt];
            end
          end else begin
            // Stalled edge: hold position, keep the datapath idle.
            c_q   <= NOP_C;
            imm_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c    = c_q;
  assign bus.imm  = imm_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pc   = pc_q;

endmodule
